// File: rtl/nsa_pkg.sv
// Shared types and constants for the nibble-serial adder.
package nsa_pkg;

  localparam int NSA_SLICE_W = 4;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } nsa_state_t;

endpackage

// File: rtl/slice_add4.sv
// Combinational 4-bit ripple-carry adder built from full_adder cells.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

module slice_add4
  import nsa_pkg::*;
(
  input  logic [NSA_SLICE_W-1:0] a,
  input  logic [NSA_SLICE_W-1:0] b,
  input  logic                   cin,
  output logic [NSA_SLICE_W-1:0] sum,
  output logic                   cout
);

  logic [NSA_SLICE_W:0] carry;

  assign carry[0] = cin;

  for (genvar i = 0; i < NSA_SLICE_W; i++) begin : g_fa
    full_adder u_fa (
      .a    (a[i]),
      .b    (b[i]),
      .cin  (carry[i]),
      .sum  (sum[i]),
      .cout (carry[i+1])
    );
  end

  assign cout = carry[NSA_SLICE_W];

endmodule

// File: rtl/nibble_serial_adder.sv
// Multi-cycle WIDTH-bit unsigned adder, one 4-bit slice per clock, valid/ready on both sides.
// Define NIBBLE_SERIAL_ADDER_OVERFLOW_EN to add a signed-overflow output.
module nibble_serial_adder
  import nsa_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef NIBBLE_SERIAL_ADDER_OVERFLOW_EN
  ,
  output logic             overflow
`endif
);

  // WIDTH must be a multiple of 4 and at least 4.
  localparam int NSLICE = WIDTH / NSA_SLICE_W;
  localparam int CW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [CW-1:0] LAST = CW'(NSLICE - 1);

  nsa_state_t             state;
  logic [WIDTH-1:0]       a_q;
  logic [WIDTH-1:0]       b_q;
  logic                   carry_q;
  logic [CW-1:0]          slice_cnt;
  logic [NSA_SLICE_W-1:0] s_a;
  logic [NSA_SLICE_W-1:0] s_b;
  logic [NSA_SLICE_W-1:0] s_sum;
  logic                   s_cout;

  assign s_a = a_q[NSA_SLICE_W*slice_cnt +: NSA_SLICE_W];
  assign s_b = b_q[NSA_SLICE_W*slice_cnt +: NSA_SLICE_W];

  slice_add4 u_slice (
    .a    (s_a),
    .b    (s_b),
    .cin  (carry_q),
    .sum  (s_sum),
    .cout (s_cout)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      sum       <= '0;
      cout      <= 1'b0;
      slice_cnt <= '0;
      carry_q   <= 1'b0;
      a_q       <= '0;
      b_q       <= '0;
`ifdef NIBBLE_SERIAL_ADDER_OVERFLOW_EN
      overflow  <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_q       <= a;
            b_q       <= b;
            carry_q   <= cin;
            slice_cnt <= '0;
            in_ready  <= 1'b0;
            state     <= RUN;
          end
        end
        RUN: begin
          sum[NSA_SLICE_W*slice_cnt +: NSA_SLICE_W] <= s_sum;
          carry_q   <= s_cout;
          slice_cnt <= slice_cnt + 1'b1;
          if (slice_cnt == LAST) begin
            cout      <= s_cout;
`ifdef NIBBLE_SERIAL_ADDER_OVERFLOW_EN
            // Carry into the MSB is recovered as a^b^sum at that bit.
            overflow  <= a_q[WIDTH-1] ^ b_q[WIDTH-1] ^ s_sum[NSA_SLICE_W-1] ^ s_cout;
`endif
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Directed self-checking bench for nibble_serial_adder at WIDTH=16.
module tb_nibble_serial_adder;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a;
  logic [15:0] b;
  logic        cin;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] sum;
  logic        cout;
`ifdef NIBBLE_SERIAL_ADDER_OVERFLOW_EN
  logic        overflow;
`endif

  int vectors    = 0;
  int miscompares = 0;
  int cyc        = 0;

  nibble_serial_adder #(.WIDTH(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout)
`ifdef NIBBLE_SERIAL_ADDER_OVERFLOW_EN
    ,
    .overflow  (overflow)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    if (observed !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, observed, expected, $time);
    end
  endtask

  // Presents operands and returns once they are accepted; acc is the cycle count just after the accept edge.
  task automatic applyStimulus(input logic [15:0] ta, input logic [15:0] tb, input logic tc,
                               input bit keep_valid, output int acc);
    int n;
    @(negedge clk);
    a = ta; b = tb; cin = tc; in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) checkOutput("accept_timeout", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    acc = cyc;
    if (!keep_valid) in_valid = 1'b0;
  endtask

  task automatic waitResult(input string tag, input logic [15:0] es, input logic ec, input logic eo);
    int lat;
    lat = 0;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk);
      #1;
      if (out_valid) begin
        lat = k;
        break;
      end
    end
    checkOutput({tag, "_latency"}, 32'(lat), 32'd4);
    checkOutput({tag, "_sum"}, 32'(sum), 32'(es));
    checkOutput({tag, "_cout"}, 32'(cout), 32'(ec));
`ifdef NIBBLE_SERIAL_ADDER_OVERFLOW_EN
    checkOutput({tag, "_ovf"}, 32'(overflow), 32'(eo));
`else
    if (eo !== eo) checkOutput({tag, "_ovf_x"}, 32'(eo), 32'd0);
`endif
  endtask

  task automatic releaseResult();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  initial begin
    int acc;
    int prev_acc;
    int hs;
    logic [15:0] hold_sum;
    logic        hold_cout;
    logic [15:0] ra, rb;
    logic        rc;
    logic [16:0] ref_sum;
    logic        ref_ovf;

    rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    checkOutput("reset_in_ready", 32'(in_ready), 32'd1);
    checkOutput("reset_out_valid", 32'(out_valid), 32'd0);
    checkOutput("reset_sum", 32'(sum), 32'd0);
    checkOutput("reset_cout", 32'(cout), 32'd0);

    // Basic add
    applyStimulus(16'h1234, 16'h4321, 1'b0, 1'b0, acc);
    checkOutput("run_in_ready", 32'(in_ready), 32'd0);
    waitResult("basic", 16'h5555, 1'b0, 1'b0);
    checkOutput("done_in_ready", 32'(in_ready), 32'd0);
    releaseResult();
    checkOutput("basic_released", 32'(out_valid), 32'd0);

    // Full carry chain with wrap-around
    applyStimulus(16'hFFFF, 16'h0000, 1'b1, 1'b0, acc);
    waitResult("carry", 16'h0000, 1'b1, 1'b0);
    releaseResult();

    // Signed overflow
    applyStimulus(16'h7FFF, 16'h0001, 1'b0, 1'b0, acc);
    waitResult("sovf", 16'h8000, 1'b0, 1'b1);
    releaseResult();

    // Output backpressure with a new request already waiting
    applyStimulus(16'h1111, 16'h2222, 1'b0, 1'b0, acc);
    a = 16'hDEAD; b = 16'hBEEF; cin = 1'b1;
    waitResult("bp", 16'h3333, 1'b0, 1'b0);
    hold_sum = 16'h3333; hold_cout = 1'b0;
    a = 16'h0001; b = 16'h0001; cin = 1'b0; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checkOutput("bp_sum_stable", 32'(sum), 32'(hold_sum));
      checkOutput("bp_cout_stable", 32'(cout), 32'(hold_cout));
      checkOutput("bp_in_ready", 32'(in_ready), 32'd0);
      checkOutput("bp_out_valid", 32'(out_valid), 32'd1);
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    hs = cyc;
    out_ready = 1'b0;
    checkOutput("bp_handshake_drop", 32'(out_valid), 32'd0);
    checkOutput("bp_idle_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    acc = cyc;
    in_valid = 1'b0;
    checkOutput("bp_first_idle_accept", 32'(acc - hs), 32'd1);
    checkOutput("bp_accepted", 32'(in_ready), 32'd0);
    waitResult("bp_next", 16'h0002, 1'b0, 1'b0);
    releaseResult();

    // Reset in the middle of an operation
    applyStimulus(16'hAAAA, 16'h5555, 1'b0, 1'b0, acc);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    checkOutput("mid_rst_out_valid", 32'(out_valid), 32'd0);
    checkOutput("mid_rst_in_ready", 32'(in_ready), 32'd1);
    checkOutput("mid_rst_sum", 32'(sum), 32'd0);
    checkOutput("mid_rst_cout", 32'(cout), 32'd0);
    repeat (6) @(posedge clk);
    #1;
    checkOutput("mid_rst_no_result", 32'(out_valid), 32'd0);
    applyStimulus(16'h0F0F, 16'h00F1, 1'b0, 1'b0, acc);
    waitResult("post_rst", 16'h1000, 1'b0, 1'b0);
    releaseResult();

    // Back-to-back with out_ready tied high
    out_ready = 1'b1;
    prev_acc = 0;
    for (int i = 0; i < 8; i++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      rc = 1'($urandom);
      if (i == 0) begin
        ra = 16'h8000; rb = 16'h8000; rc = 1'b0;
      end
      ref_sum = {1'b0, ra} + {1'b0, rb} + {16'd0, rc};
      ref_ovf = (ra[15] == rb[15]) && (ref_sum[15] != ra[15]);
      applyStimulus(ra, rb, rc, 1'b1, acc);
      if (i > 0) checkOutput("b2b_spacing", 32'(acc - prev_acc), 32'd6);
      prev_acc = acc;
      waitResult("b2b", ref_sum[15:0], ref_sum[16], ref_ovf);
    end
    in_valid = 1'b0;
    out_ready = 1'b0;
    repeat (3) @(posedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
